// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit hex display driver with an internal refresh prescaler,
// double-buffered display value, per-digit blanking, decimal points and leading-zero suppression.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_done
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEGS_OFF  = {7{ACTIVE_LOW}};

  logic [PRE_W-1:0]        prescaler;
  logic                    tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] shadow_digits, disp_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   shadow_en, disp_en;

  logic [NUM_DIGITS-1:0]   lead_zero;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_supp;
  logic [NUM_DIGITS-1:0]   next_anode_al;
  logic [6:0]              next_segs_al;
  logic                    next_dp_al;

  function automatic logic [6:0] hex_to_segs(input logic [3:0] v);
    case (v)
      4'h0: hex_to_segs = 7'h40;
      4'h1: hex_to_segs = 7'h79;
      4'h2: hex_to_segs = 7'h24;
      4'h3: hex_to_segs = 7'h30;
      4'h4: hex_to_segs = 7'h19;
      4'h5: hex_to_segs = 7'h12;
      4'h6: hex_to_segs = 7'h02;
      4'h7: hex_to_segs = 7'h78;
      4'h8: hex_to_segs = 7'h00;
      4'h9: hex_to_segs = 7'h10;
      4'hA: hex_to_segs = 7'h08;
      4'hB: hex_to_segs = 7'h03;
      4'hC: hex_to_segs = 7'h46;
      4'hD: hex_to_segs = 7'h21;
      4'hE: hex_to_segs = 7'h06;
      default: hex_to_segs = 7'h0E;
    endcase
  endfunction

  assign tick = (prescaler == PRE_LAST);
  assign wrap = tick && (scan_idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler  <= '0;
      scan_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + PRE_W'(1);
      frame_done <= wrap;
      if (tick) scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  // Display only updates on the frame boundary so a frame never mixes two values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_en     <= '0;
      disp_digits   <= '0;
      disp_dp       <= '0;
      disp_en       <= '0;
    end else begin
      if (load) begin
        shadow_digits <= digits;
        shadow_dp     <= dp_in;
        shadow_en     <= digit_en;
      end
      if (wrap) begin
        disp_digits <= shadow_digits;
        disp_dp     <= shadow_dp;
        disp_en     <= shadow_en;
      end
    end
  end

  // Leading-zero run is computed from the most significant digit downwards.
  always_comb begin
    zero_run   = 1'b1;
    lead_zero  = '0;
    sel_onehot = '0;
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_supp   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_digits[i*4 +: 4] == 4'h0);
      lead_zero[i] = zero_run && (i != 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        cur_nib       = disp_digits[i*4 +: 4];
        cur_dp        = disp_dp[i];
        cur_en        = disp_en[i];
        cur_supp      = lead_zero[i];
      end
    end
    next_anode_al = ~(sel_onehot & {NUM_DIGITS{cur_en}});
    next_segs_al  = 7'h7F;
    next_dp_al    = 1'b1;
    if (cur_en) begin
      next_dp_al = ~cur_dp;
      if (!(lz_suppress && cur_supp)) next_segs_al = hex_to_segs(cur_nib);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode <= ANODE_OFF;
      segs  <= SEGS_OFF;
      dp    <= ACTIVE_LOW;
    end else if (ACTIVE_LOW) begin
      anode <= next_anode_al;
      segs  <= next_segs_al;
      dp    <= next_dp_al;
    end else begin
      anode <= ~next_anode_al;
      segs  <= ~next_segs_al;
      dp    <= ~next_dp_al;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Table-driven bench for seven_seg_scanner: 4 digits, 4 clocks per slot, both output polarities
// driven from the same inputs.
module tb_seven_seg_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic        lz_suppress;

  logic [3:0]  anode_lo, anode_hi;
  logic [6:0]  segs_lo, segs_hi;
  logic        dp_lo, dp_hi;
  logic [1:0]  scan_idx_lo, scan_idx_hi;
  logic        frame_done_lo, frame_done_hi;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  en;
    logic        lz;
    logic [15:0] ea;
    logic [27:0] es;
    logic [3:0]  ed;
  } vec_t;

  vec_t vecs[8];

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .lz_suppress(lz_suppress), .anode(anode_lo), .segs(segs_lo),
    .dp(dp_lo), .scan_idx(scan_idx_lo), .frame_done(frame_done_lo)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .lz_suppress(lz_suppress), .anode(anode_hi), .segs(segs_hi),
    .dp(dp_hi), .scan_idx(scan_idx_hi), .frame_done(frame_done_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    compare({tag, "_anode_lo"}, 32'(anode_lo), 32'h0000000F);
    compare({tag, "_segs_lo"}, 32'(segs_lo), 32'h0000007F);
    compare({tag, "_dp_lo"}, 32'(dp_lo), 32'h1);
    compare({tag, "_scan_idx"}, 32'(scan_idx_lo), 32'h0);
    compare({tag, "_frame_done"}, 32'(frame_done_lo), 32'h0);
    compare({tag, "_anode_hi"}, 32'(anode_hi), 32'h0);
    compare({tag, "_segs_hi"}, 32'(segs_hi), 32'h0);
    compare({tag, "_dp_hi"}, 32'(dp_hi), 32'h0);
    compare({tag, "_frame_done_hi"}, 32'(frame_done_hi), 32'h0);
  endtask

  task automatic checkOutput(input string tag, input int k, input logic [3:0] ea,
                             input logic [6:0] es, input logic ed);
    logic [3:0] ia;
    logic [6:0] is;
    logic       id;
    ia = ~ea;
    is = ~es;
    id = ~ed;
    compare($sformatf("%s_s%0d_anode", tag, k), 32'(anode_lo), 32'(ea));
    compare($sformatf("%s_s%0d_segs", tag, k), 32'(segs_lo), 32'(es));
    compare($sformatf("%s_s%0d_dp", tag, k), 32'(dp_lo), 32'(ed));
    compare($sformatf("%s_s%0d_idx", tag, k), 32'(scan_idx_lo), 32'(k));
    compare($sformatf("%s_s%0d_anode_hi", tag, k), 32'(anode_hi), 32'(ia));
    compare($sformatf("%s_s%0d_segs_hi", tag, k), 32'(segs_hi), 32'(is));
    compare($sformatf("%s_s%0d_dp_hi", tag, k), 32'(dp_hi), 32'(id));
    compare($sformatf("%s_s%0d_idx_hi", tag, k), 32'(scan_idx_hi), 32'(k));
  endtask

  // Returns on the negedge where frame_done is seen high (just after the wrapping edge).
  task automatic wait_frame(input string tag);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      if (frame_done_lo) seen = 1'b1;
      cyc++;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL %s_frame_wait: got no frame_done in 64 cycles, expected one", tag);
    end
  endtask

  // Called right after wait_frame; samples the middle of each of the four slots.
  task automatic check_frame(input string tag, input logic [15:0] ea,
                             input logic [27:0] es, input logic [3:0] ed);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        repeat (4) @(posedge clk);
        @(negedge clk);
      end
      checkOutput(tag, k, ea[k*4 +: 4], es[k*7 +: 7], ed[k]);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    digits      = v.digits;
    dp_in       = v.dp_in;
    digit_en    = v.en;
    lz_suppress = v.lz;
    load        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int pulses;

    vecs[0] = '{16'h1234, 4'b0000, 4'hF, 1'b0, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
    vecs[1] = '{16'hABCD, 4'b0000, 4'hF, 1'b0, 16'h7BDE, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF};
    vecs[2] = '{16'h0050, 4'b0000, 4'hF, 1'b1, 16'h7BDE, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
    vecs[3] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 16'h7BDE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
    vecs[4] = '{16'h0050, 4'b0000, 4'hF, 1'b0, 16'h7BDE, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
    vecs[5] = '{16'h8888, 4'b0010, 4'b1010, 1'b0, 16'h7FDF, {7'h00, 7'h7F, 7'h00, 7'h7F}, 4'b1101};
    vecs[6] = '{16'h0001, 4'b0000, 4'hF, 1'b0, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h79}, 4'hF};
    vecs[7] = '{16'h0050, 4'b0100, 4'hF, 1'b1, 16'h7BDE, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1011};

    rst         = 1'b0;
    digits      = '0;
    dp_in       = '0;
    digit_en    = '0;
    load        = 1'b0;
    lz_suppress = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      wait_frame($sformatf("v%0d_pre", v));
      applyStimulus(vecs[v]);
      wait_frame($sformatf("v%0d", v));
      check_frame($sformatf("v%0d", v), vecs[v].ea, vecs[v].es, vecs[v].ed);
    end

    pulses = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (frame_done_lo) pulses++;
    end
    compare("frame_done_rate", 32'(pulses), 32'd2);

    // Mid-frame load must not disturb the frame already on display.
    wait_frame("tear_pre");
    applyStimulus(vecs[0]);
    wait_frame("tear_a");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("tear_old", 0, 4'b1110, 7'h19, 1'b1);
    digits = 16'hABCD;
    load   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("tear_old", 1, 4'b1101, 7'h30, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("tear_old", 2, 4'b1011, 7'h24, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("tear_old", 3, 4'b0111, 7'h79, 1'b1);
    wait_frame("tear_b");
    check_frame("tear_new", vecs[1].ea, vecs[1].es, vecs[1].ed);

    // Load on the wrapping edge itself: old shadow shown this frame, new value the next.
    @(posedge clk);
    @(negedge clk);
    digits = 16'h5555;
    load   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    compare("wrap_load_frame_done", 32'(frame_done_lo), 32'h1);
    check_frame("wrap_load_old", vecs[1].ea, vecs[1].es, vecs[1].ed);
    wait_frame("wrap_load");
    check_frame("wrap_load_new", 16'h7BDE, {7'h12, 7'h12, 7'h12, 7'h12}, 4'hF);

    // Asynchronous reset in the middle of slot 3.
    #2 rst = 1'b1;
    #1 check_reset("mid_scan");
    @(negedge clk);
    rst = 1'b0;
    wait_frame("post_reset");
    check_frame("post_reset", 16'hFFFF, 28'hFFFFFFF, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
